// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel output path.
package sobel_pkg;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // 100 MHz clk_a at 115200 baud
   localparam int unsigned SOBEL_CLKS_PER_BIT = 868;

endpackage

// File: rtl/sobel_uart_tx_sync_fifo.sv
// Single-clock byte FIFO; writes ignored when full, reads ignored when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push_c, do_pop_c;

   assign full_o    = (count_q == CNT_W'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_push_c = push_i && !full_o;
   assign do_pop_c  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rd_q];
   assign count_o   = count_q;

   always_ff @(posedge clk_i) begin
      if (do_push_c) mem_q[wr_q] <= wdata_i;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push_c) wr_q <= wr_q + PTR_W'(1);
         if (do_pop_c)  rd_q <= rd_q + PTR_W'(1);
         case ({do_push_c, do_pop_c})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/sobel_uart_tx.sv
// Buffers Sobel magnitude bytes and serialises them as 8N1-style UART frames.
module sobel_uart_tx
   import sobel_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = SOBEL_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                          clk_a,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          data_in,
   input  logic                          valid_in,
   output logic                          ready_in,
   output logic                          tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned BAUD_W = 16;
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

   tx_state_t              state_q;
   logic [BAUD_W-1:0]      baud_q;
   logic [BIT_W-1:0]       bit_q;
   logic [DATA_BITS-1:0]   shreg_q;
   logic                   tx_q;
   logic                   overflow_q;

   logic                   fifo_full, fifo_empty;
   logic [DATA_BITS-1:0]   fifo_rdata;
   logic                   fifo_push_c, fifo_pop_c, baud_term_c;

   assign ready_in    = !fifo_full;
   assign fifo_push_c = valid_in && ready_in;
   assign baud_term_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   // Pop from IDLE, or chain straight into the next frame at the end of STOP
   always_comb begin
      fifo_pop_c = 1'b0;
      if (!fifo_empty) begin
         if (state_q == TX_IDLE)                  fifo_pop_c = 1'b1;
         else if (state_q == TX_STOP && baud_term_c) fifo_pop_c = 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_a),
      .rst_i   (rst),
      .push_i  (fifo_push_c),
      .wdata_i (data_in),
      .pop_i   (fifo_pop_c),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // tx is registered from the current state, so the line lags the state by one cycle
   always_ff @(posedge clk_a) begin
      if (rst) begin
         state_q    <= TX_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (valid_in && fifo_full) overflow_q <= 1'b1;

         case (state_q)
            TX_START: tx_q <= 1'b0;
            TX_DATA:  tx_q <= shreg_q[0];
            default:  tx_q <= 1'b1;
         endcase

         case (state_q)
            TX_IDLE: begin
               if (fifo_pop_c) begin
                  shreg_q <= fifo_rdata;
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               if (baud_term_c) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= TX_DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            TX_DATA: begin
               if (baud_term_c) begin
                  baud_q  <= '0;
                  shreg_q <= shreg_q >> 1;
                  if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                     bit_q   <= '0;
                     state_q <= TX_STOP;
                  end else begin
                     bit_q <= bit_q + BIT_W'(1);
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            TX_STOP: begin
               if (baud_term_c) begin
                  baud_q <= '0;
                  if (fifo_pop_c) begin
                     shreg_q <= fifo_rdata;
                     state_q <= TX_START;
                  end else begin
                     state_q <= TX_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: state_q <= TX_IDLE;
         endcase
      end
   end

   assign tx       = tx_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != TX_IDLE) || (fifo_count != '0);

endmodule

// File: doc/sobel_uart_tx.md
SOBEL_UART_TX -- requirements
Module: sobel_uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, width of one pixel byte and of one UART character.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk_a cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 16, byte FIFO entries; power of two, at least 2.
REQ-004 clk_a  input  1  clock; all logic rising-edge on clk_a.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_in  input  DATA_BITS  Sobel magnitude byte from the upstream sobel stage.
REQ-007 valid_in  input  1  data_in valid this cycle.
REQ-008 ready_in  output  1  FIFO can accept a byte this cycle; drives the upstream ready_out.
REQ-009 tx  output  1  UART serial line, idle high.
REQ-010 busy  output  1  high while a frame is on tx or the FIFO is non-empty.
REQ-011 overflow  output  1  sticky flag: a byte was offered while the FIFO was full.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Byte accepted when valid_in && ready_in at a rising edge; written at the FIFO tail on that edge.
REQ-014 ready_in = (fifo_count != FIFO_DEPTH), combinational from registered count; no dependence on valid_in.
REQ-015 valid_in while full: byte dropped, FIFO unchanged, overflow set on that edge; remains set until rst.
REQ-016 Simultaneous pop and offered push while full: push rejected (ready_in already low); count decrements by 1.
REQ-017 Simultaneous accepted push and pop on a non-full, non-empty FIFO: count unchanged, both pointers advance.
REQ-018 Pointers wrap modulo FIFO_DEPTH; count saturates neither below 0 nor above FIFO_DEPTH.
REQ-019 TX FSM states IDLE, START, DATA, STOP; tx registered, driven 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA.
REQ-020 IDLE: if FIFO non-empty, pop head into shift register, clear baud counter, go to START on that edge.
REQ-021 Each state holds exactly CLKS_PER_BIT cycles via a baud counter counting 0..CLKS_PER_BIT-1.
REQ-022 DATA: DATA_BITS bits, LSB first; shift right and increment bit index at each baud-counter terminal count; after bit DATA_BITS-1 go to STOP.
REQ-023 STOP terminal count: if FIFO non-empty, pop and go directly to START (no idle cycle); else go to IDLE.
REQ-024 Back-to-back frames therefore occupy exactly (DATA_BITS+2)*CLKS_PER_BIT cycles each.
REQ-025 Latency: byte accepted into an empty FIFO with FSM in IDLE at edge N -> popped at edge N+1 -> tx low from edge N+2.
REQ-026 busy = (state != IDLE) || (fifo_count != 0).
REQ-027 Byte order on tx equals acceptance order; no byte duplicated or reordered.

Reset
REQ-028 On rst: state IDLE, tx 1, baud counter 0, bit index 0, FIFO pointers and count 0, overflow 0, ready_in 1, busy 0.
REQ-029 rst mid-frame: tx returns high on the next edge, frame truncated, all FIFO content discarded; no partial resume.
REQ-030 Valid_in during rst ignored; first acceptance on the first edge with rst low.

Structure
REQ-031 tx_state_t enum and default CLKS_PER_BIT constant live in shared package sobel_pkg.
REQ-032 FIFO is sub-module sync_fifo (single clock, params WIDTH, DEPTH; push/pop/full/empty/count); serializer FSM stays in sobel_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Single byte 0xA5 into idle block -> tx low from 2 edges after acceptance, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, busy low after.
REQ-034 Push 0x01,0x02,0x03 on consecutive cycles -> three frames back-to-back, 40 cycles each, no idle gap, order 01,02,03.
REQ-035 Push 6 bytes consecutively into empty FIFO -> first byte popped, next 4 stored, 6th dropped, overflow=1, ready_in low while count=4.
REQ-036 Full FIFO with valid_in held high across a STOP->START pop -> count 4->3, offered byte on pop edge dropped, accepted the following cycle.
REQ-037 Assert rst during bit 3 of a frame with 2 bytes queued -> tx=1, fifo_count=0, overflow=0, busy=0 next edge; fresh byte afterwards transmits correctly.
